dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. It accepts the MemRead/MemWrite request driven from the EX/MEM pipeline register and holds the pipeline with `stall_o` for a fixed, parameterised access latency. It then completes the access against an internal word array and returns read data with a one-cycle `ack_o`. It replaces the zero-latency data memory so the core can be exercised against realistic memory timing.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array. Power of two.
- `LATENCY`, 4: cycles from request acceptance to completion. Legal range 1..15.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_read_i`  in  1  MemRead from EX/MEM.
- `req_write_i`  in  1  MemWrite from EX/MEM.
- `addr_i`  in  32  byte address (ALU result from EX/MEM).
- `wdata_i`  in  32  store data from EX/MEM.
- `rdata_o`  out  32  registered load data to MEM/WB.
- `ack_o`  out  1  one-cycle pulse marking completion of an access.
- `stall_o`  out  1  freezes PC, IF/ID, ID/EX, EX/MEM while high.
- `err_o`  out  1  one-cycle pulse, coincident with `ack_o`, marking an illegal request.

## Operation
- States: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` tracks the latency.
- **IDLE**
  - A request is present when `req_read_i | req_write_i`.
  - On a request, latch `addr_i`, `wdata_i` and the op, and compute `illegal`.
  - If `LATENCY==1`, go to DONE. Otherwise load `cnt=LATENCY-2` and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - When `cnt==0`, go to DONE. Otherwise decrement `cnt`.
- **Access**
  - Performed on the clock edge that enters DONE, using the latched values only.
  - Write: `mem[addr[31:2]] <= wdata`.
  - Read: `rdata_o <= mem[addr[31:2]]`.
- **Illegal requests**
  - A request is illegal if `addr[1:0]!=0`, or `addr[31:2]>=DEPTH`, or read and write are asserted together.
  - An illegal request consumes the full latency but performs no array access, and `rdata_o` is unchanged.
- **DONE**
  - `ack_o=1`, `err_o=illegal`, `stall_o=0`.
  - Always returns to IDLE next cycle. The request inputs are ignored in DONE, because they still carry the instruction that is just being released.
- **Outputs**
  - `stall_o = (IDLE & request) | BUSY`. This is combinational so the pipeline freezes in the acceptance cycle.
  - `ack_o` and `err_o` are decoded from DONE.
  - `rdata_o` holds its last loaded value between reads.
- The array is not reset, and its contents are undefined until written. The bench preloads it through hierarchical access.

## Timing
- Acceptance cycle T (IDLE with a request present).
- `stall_o` is high for cycles T..T+LATENCY-1, i.e. exactly `LATENCY` cycles.
- `ack_o`, `rdata_o` valid and `err_o` all appear at cycle T+LATENCY. MEM/WB captures `rdata_o` on the edge ending T+LATENCY.
- Back-to-back accesses: earliest next acceptance is T+LATENCY+1. There is no dead cycle beyond DONE.
- A load issued immediately after a store to the same word returns the stored data, because the write completes before the next acceptance.
- Reset values (asynchronous, any state, including mid-access):
  - state IDLE, `cnt=0`, `rdata_o=0`;
  - `ack_o`, `err_o`, `stall_o` all 0 (while no request is present after reset);
  - a pending write is dropped and the array is left untouched.
- After reset deassertion, a request present on the first edge is accepted normally.

## Test plan
- **Read, LATENCY=4:** preload `mem[5]=32'h1234_5678`; read `addr=0x14` at T → `stall_o` high T..T+3, `ack_o` and `rdata_o=0x12345678` at T+4, `err_o=0`.
- **Store then load, LATENCY=4:** write `0xCAFEBABE` to `0x40`, then read `0x40` → two 4-cycle stalls separated by one DONE cycle; the read returns `0xCAFEBABE`.
- **LATENCY=1:** read `0x0` with `mem[0]=7` → `stall_o` only in cycle T, `ack_o` and `rdata_o=7` at T+1.
- **Illegal requests:** read `0x13` → `err_o` and `ack_o` at T+LATENCY, `rdata_o` keeps its prior value. Read+write together at `0x8` → `err_o`, and `mem[2]` is unchanged.
- **Reset mid-write:** start a write of `0xFFFF_FFFF` to `0x20` (old value `0x11`); assert `rst_i` at T+2 → `stall_o` drops immediately, no `ack_o`, `mem[8]` stays `0x11`, `rdata_o=0`.
- **No request:** both request inputs held low for 20 cycles → `stall_o`, `ack_o` and `err_o` stay 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts a load/store,
// stalls the pipeline for LATENCY cycles, then completes the access with a one-cycle ack.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic        LAT_ONE  = (LATENCY == 1);
  localparam logic [3:0]  LAT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Misaligned, out-of-range, or simultaneous read+write requests are rejected.
  function automatic logic is_illegal(input logic rd, input logic wr, input logic [31:0] addr);
    logic [29:0] widx;
    widx       = addr[31:2];
    is_illegal = (addr[1:0] != 2'b00) || (widx >= DEPTH_W) || (rd && wr);
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      cnt_r, cnt_s;
  logic [AW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic            rd_r, wr_r, illegal_r;
  logic [31:0]     mem_r [0:DEPTH-1];

  logic            req_s;
  logic            accept_s;
  logic            stall_s;
  logic [AW-1:0]   idx_s;
  logic [31:0]     wdata_s;
  logic            rd_s, wr_s, illegal_s;
  logic            access_s;
  logic            mem_we_s;
  logic            rd_en_s;

  assign req_s = req_read_i | req_write_i;

  // Next-state, latency counter and stall decode.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    stall_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          accept_s = 1'b1;
          stall_s  = 1'b1;
          if (LAT_ONE) begin
            state_s = S_DONE;
          end else begin
            cnt_s   = LAT_LOAD;
            state_s = S_BUSY;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_s = 1'b1;
        if (cnt_r == 4'd0) begin
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // With LATENCY==1 the access happens on the acceptance edge, so the operands
  // come straight from the request inputs instead of the (not yet loaded) latches.
  always_comb begin
    idx_s     = idx_r;
    wdata_s   = wdata_r;
    rd_s      = rd_r;
    wr_s      = wr_r;
    illegal_s = illegal_r;
    if (accept_s) begin
      idx_s     = addr_i[AW+1:2];
      wdata_s   = wdata_i;
      rd_s      = req_read_i;
      wr_s      = req_write_i;
      illegal_s = is_illegal(req_read_i, req_write_i, addr_i);
    end else begin
      idx_s     = idx_r;
    end
  end

  assign access_s = (state_s == S_DONE) && (state_r != S_DONE) && !illegal_s;
  assign mem_we_s = access_s && wr_s && !rst_i;
  assign rd_en_s  = access_s && rd_s;

  // Control state, counter and request latches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= '0;
      wdata_r   <= 32'd0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        idx_r     <= addr_i[AW+1:2];
        wdata_r   <= wdata_i;
        rd_r      <= req_read_i;
        wr_r      <= req_write_i;
        illegal_r <= is_illegal(req_read_i, req_write_i, addr_i);
      end
    end
  end

  // Load data register; holds its value between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= 32'd0;
    end else if (rd_en_s) begin
      rdata_o <= mem_r[idx_s];
    end
  end

  // Word array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= wdata_s;
    end
  end

  assign stall_o = stall_s;
  assign ack_o   = (state_r == S_DONE);
  assign err_o   = (state_r == S_DONE) && illegal_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with LATENCY=4 and LATENCY=1 instances.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rd4 = 1'b0, wr4 = 1'b0;
  logic [31:0] addr4 = 32'd0, wdata4 = 32'd0;
  logic [31:0] rdata4;
  logic        ack4, stall4, err4;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
  logic [31:0] rdata1;
  logic        ack1, stall1, err1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .req_read_i(rd4), .req_write_i(wr4), .addr_i(addr4), .wdata_i(wdata4),
    .rdata_o(rdata4), .ack_o(ack4), .stall_o(stall4), .err_o(err4)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_read_i(rd1), .req_write_i(wr1), .addr_i(addr1), .wdata_i(wdata1),
    .rdata_o(rdata1), .ack_o(ack1), .stall_o(stall1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access on the LATENCY=4 instance; request held through the stall.
  task automatic run4(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err);
    rd4 = rd; wr4 = wr; addr4 = a; wdata4 = wd;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_stall"}, {31'd0, stall4}, 32'd1);
      chk({tag, "_noack"}, {31'd0, ack4}, 32'd0);
      tick();
    end
    chk({tag, "_ack"}, {31'd0, ack4}, 32'd1);
    chk({tag, "_err"}, {31'd0, err4}, {31'd0, exp_err});
    chk({tag, "_done_stall"}, {31'd0, stall4}, 32'd0);
    chk({tag, "_rdata"}, rdata4, exp_rdata);
    rd4 = 1'b0; wr4 = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, {31'd0, ack4}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_stall4", {31'd0, stall4}, 32'd0);
    chk("rst_ack4", {31'd0, ack4}, 32'd0);
    chk("rst_err4", {31'd0, err4}, 32'd0);
    chk("rst_rdata4", rdata4, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    dut4.mem_r[5] = 32'h1234_5678;
    dut4.mem_r[2] = 32'hA5A5_0002;
    dut4.mem_r[8] = 32'h0000_0011;
    dut1.mem_r[0] = 32'h0000_0007;

    // Plain read, then store followed immediately by load of same word
    run4("rd14", 1'b1, 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0);
    run4("wr40", 1'b0, 1'b1, 32'h40, 32'hCAFE_BABE, 32'h1234_5678, 1'b0);
    run4("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE_BABE, 1'b0);
    chk("mem16", dut4.mem_r[16], 32'hCAFE_BABE);

    // Illegal requests keep rdata and leave the array alone
    run4("misalign", 1'b1, 1'b0, 32'h13, 32'h0, 32'hCAFE_BABE, 1'b1);
    run4("rdwr", 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b1);
    chk("mem2_kept", dut4.mem_r[2], 32'hA5A5_0002);
    run4("range", 1'b1, 1'b0, 32'h1000, 32'h0, 32'hCAFE_BABE, 1'b1);
    run4("last_word", 1'b1, 1'b0, 32'hFFC, 32'h0, dut4.mem_r[1023], 1'b0);

    // LATENCY=1: stall only in the acceptance cycle
    rd1 = 1'b1; addr1 = 32'h0;
    #1;
    chk("l1_stall", {31'd0, stall1}, 32'd1);
    tick();
    chk("l1_ack", {31'd0, ack1}, 32'd1);
    chk("l1_nostall", {31'd0, stall1}, 32'd0);
    chk("l1_rdata", rdata1, 32'd7);
    chk("l1_err", {31'd0, err1}, 32'd0);
    rd1 = 1'b0;
    tick();
    rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h55;
    tick();
    chk("l1_wr_ack", {31'd0, ack1}, 32'd1);
    wr1 = 1'b0;
    tick();
    rd1 = 1'b1; addr1 = 32'h4;
    tick();
    chk("l1_rd_back", rdata1, 32'h55);
    rd1 = 1'b0;
    tick();

    // Idle: no request for 20 cycles
    for (int i = 0; i < 20; i++) begin
      chk("idle_stall", {31'd0, stall4}, 32'd0);
      chk("idle_ack", {31'd0, ack4}, 32'd0);
      chk("idle_err", {31'd0, err4}, 32'd0);
      tick();
    end

    // Reset in the middle of a write
    wr4 = 1'b1; addr4 = 32'h20; wdata4 = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("mw_stall", {31'd0, stall4}, 32'd1);
    rst = 1'b1; wr4 = 1'b0;
    #1;
    chk("mw_stall_drop", {31'd0, stall4}, 32'd0);
    chk("mw_rdata", rdata4, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mw_noack", {31'd0, ack4}, 32'd0);
      tick();
    end
    rst = 1'b0;
    chk("mw_mem8", dut4.mem_r[8], 32'h0000_0011);

    // Request on the very first edge after reset release
    run4("post_rst", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0000_0011, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
